// File: rtl/song_pkg.sv
// Shared types and constants for the song loader: FSM states and the song address map.
package song_pkg;

    localparam int unsigned IDX_W      = 3;
    localparam int unsigned TBL_ADDR_W = 20;
    localparam int unsigned TBL_SONGS  = 4;

    typedef enum logic [1:0] {SRESET, FETCH, SEND, DONE} state_t;

    // End addresses are exclusive; song 1 is intentionally empty.
    localparam logic [TBL_ADDR_W-1:0] SONG_START [TBL_SONGS] =
        '{20'h00000, 20'h00010, 20'h00020, 20'h00040};
    localparam logic [TBL_ADDR_W-1:0] SONG_END [TBL_SONGS] =
        '{20'h00003, 20'h00010, 20'h00025, 20'h00044};

endpackage

// File: rtl/song_addr_table.sv
// Clamps a requested song index into the valid range and looks up its byte range.
module song_addr_table
    import song_pkg::*;
#(
    parameter int unsigned ADDR_W    = 20,
    parameter int unsigned NUM_SONGS = 4
) (
    input  logic [IDX_W-1:0]  sel,
    output logic [IDX_W-1:0]  idx,
    output logic [ADDR_W-1:0] start_addr,
    output logic [ADDR_W-1:0] end_addr
);

    localparam int unsigned N = (NUM_SONGS < TBL_SONGS) ? NUM_SONGS : TBL_SONGS;

    always_comb begin
        idx        = (32'(sel) < NUM_SONGS) ? sel : IDX_W'(NUM_SONGS - 1);
        start_addr = '0;
        end_addr   = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (idx == IDX_W'(i)) begin
                start_addr = ADDR_W'(SONG_START[i]);
                end_addr   = ADDR_W'(SONG_END[i]);
            end
        end
    end

endmodule

// File: rtl/song_loader.sv
// Streams the bytes of the selected song from storage to the MP3 decoder,
// restarting with a decoder soft reset whenever the requested index changes.
module song_loader
    import song_pkg::*;
#(
    parameter int unsigned ADDR_W     = 20,
    parameter int unsigned NUM_SONGS  = 4,
    parameter int unsigned SWITCH_GAP = 1000
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [IDX_W-1:0]  current,
    output logic              rd_req,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic              rd_ack,
    input  logic [7:0]        rd_data,
    output logic [7:0]        dec_data,
    output logic              dec_valid,
    input  logic              dec_ready,
    output logic              dec_sreset,
    output logic              song_end,
    output logic [IDX_W-1:0]  index,
    output logic              busy
);

    localparam int unsigned GAP_W = $clog2(SWITCH_GAP + 1);

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   cur_q, cur_d;
    logic [IDX_W-1:0]   index_q, index_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [ADDR_W-1:0]  end_q, end_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic [7:0]         buf_q, buf_d;
    logic               song_end_q, song_end_d;

    logic [IDX_W-1:0]   tbl_idx;
    logic [ADDR_W-1:0]  tbl_start, tbl_end;

    song_addr_table #(
        .ADDR_W    (ADDR_W),
        .NUM_SONGS (NUM_SONGS)
    ) u_table (
        .sel        (current),
        .idx        (tbl_idx),
        .start_addr (tbl_start),
        .end_addr   (tbl_end)
    );

    always_comb begin
        state_d    = state_q;
        cur_d      = cur_q;
        index_d    = index_q;
        addr_d     = addr_q;
        end_d      = end_q;
        gap_d      = gap_q;
        buf_d      = buf_q;
        song_end_d = 1'b0;

        // An index change overrides any handshake or end-of-song in the same cycle.
        if (current != cur_q) begin
            cur_d   = current;
            index_d = tbl_idx;
            addr_d  = tbl_start;
            end_d   = tbl_end;
            gap_d   = '0;
            state_d = SRESET;
        end else begin
            unique case (state_q)
                SRESET: begin
                    gap_d = gap_q + GAP_W'(1);
                    if (gap_q == GAP_W'(SWITCH_GAP - 1)) begin
                        if (addr_q == end_q) begin
                            state_d    = DONE;
                            song_end_d = 1'b1;
                        end else begin
                            state_d = FETCH;
                        end
                    end
                end
                FETCH: begin
                    if (rd_ack) begin
                        buf_d   = rd_data;
                        state_d = SEND;
                    end
                end
                SEND: begin
                    if (dec_ready) begin
                        if (addr_q + ADDR_W'(1) == end_q) begin
                            state_d    = DONE;
                            song_end_d = 1'b1;
                        end else begin
                            addr_d  = addr_q + ADDR_W'(1);
                            state_d = FETCH;
                        end
                    end
                end
                DONE: ;
                default: state_d = SRESET;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= SRESET;
            cur_q      <= current;
            index_q    <= tbl_idx;
            addr_q     <= tbl_start;
            end_q      <= tbl_end;
            gap_q      <= '0;
            buf_q      <= '0;
            song_end_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cur_q      <= cur_d;
            index_q    <= index_d;
            addr_q     <= addr_d;
            end_q      <= end_d;
            gap_q      <= gap_d;
            buf_q      <= buf_d;
            song_end_q <= song_end_d;
        end
    end

    assign rd_req     = (state_q == FETCH);
    assign rd_addr    = addr_q;
    assign dec_valid  = (state_q == SEND);
    assign dec_data   = buf_q;
    assign dec_sreset = (state_q == SRESET);
    assign song_end   = song_end_q;
    assign index      = index_q;
    assign busy       = (state_q != DONE);

endmodule

// File: tb/tb_song_loader.sv
// Randomised bench for song_loader: a scoreboard of expected bytes per song,
// filled when a (re)start is issued and drained by a monitor on decoder handshakes.
module tb_song_loader;

    localparam int GAP = 6;

    logic        CLK = 1'b0;
    logic        RST;
    logic [2:0]  current;
    logic        rd_req, rd_ack;
    logic [19:0] rd_addr;
    logic [7:0]  rd_data, dec_data;
    logic        dec_valid, dec_ready, dec_sreset, song_end, busy;
    logic [2:0]  index;

    int checks = 0;
    int errors = 0;
    int ready_pct = 60;
    int ack_force = -1;

    int song_start [4] = '{0, 'h10, 'h20, 'h40};
    int song_stop  [4] = '{3, 'h10, 'h25, 'h44};

    int exp_q [$];
    int exp_addr, exp_index, mon_cur, sel, sres_left = 0;
    int addr_prev, data_prev, resp_d, resp_a;
    bit started = 0, restart_prev = 0, restart_now;
    bit end_due = 0, fetch_due = 0, cur_end, cur_fetch, rq_hold = 0, dv_hold = 0;

    song_loader #(
        .ADDR_W     (20),
        .NUM_SONGS  (4),
        .SWITCH_GAP (GAP)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .current    (current),
        .rd_req     (rd_req),
        .rd_addr    (rd_addr),
        .rd_ack     (rd_ack),
        .rd_data    (rd_data),
        .dec_data   (dec_data),
        .dec_valid  (dec_valid),
        .dec_ready  (dec_ready),
        .dec_sreset (dec_sreset),
        .song_end   (song_end),
        .index      (index),
        .busy       (busy)
    );

    always #5 CLK = ~CLK;

    function automatic logic [7:0] mem_byte(input int a);
        return 8'((a * 37 + 11) & 255);
    endfunction

    function automatic int clampi(input int v);
        return (v < 4) ? v : 3;
    endfunction

    function automatic bit front_end();
        return (exp_q.size() > 0) && (exp_q[0] < 0);
    endfunction

    function automatic bit front_byte();
        return (exp_q.size() > 0) && (exp_q[0] >= 0);
    endfunction

    task automatic chk(input bit ok, input string name, input int act, input int req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic wait_done(input int max);
        int n = 0;
        do begin
            @(posedge CLK);
            #2;
            n++;
        end while (busy !== 1'b0 && n < max);
        if (busy !== 1'b0) chk(1'b0, "timeout_done", n, max);
    endtask

    // Storage: acknowledges each request after a random (or forced) delay.
    initial begin
        rd_ack  = 1'b0;
        rd_data = 8'd0;
        forever begin
            @(posedge CLK);
            #1;
            rd_ack = 1'b0;
            if (rd_req === 1'b1) begin
                resp_a = int'(rd_addr);
                if (ack_force >= 0) resp_d = ack_force;
                else if ($urandom_range(0, 2) == 0) resp_d = 0;
                else resp_d = int'($urandom_range(1, 5));
                if (resp_d > 0) begin
                    repeat (resp_d) @(posedge CLK);
                    #1;
                end
                rd_ack  = 1'b1;
                rd_data = mem_byte(resp_a);
            end
        end
    end

    initial begin
        dec_ready = 1'b0;
        forever begin
            @(posedge CLK);
            #1;
            dec_ready = (int'($urandom_range(1, 100)) <= ready_pct);
        end
    end

    // Monitor: observes this cycle's outputs, then decides what the coming edge does.
    always @(negedge CLK) begin
        if (started) begin
            cur_end   = end_due;
            cur_fetch = fetch_due;
            end_due   = 1'b0;
            fetch_due = 1'b0;
            if (restart_prev) begin
                chk(rd_req === 1'b0 && dec_valid === 1'b0, "restart_idle",
                    int'({rd_req, dec_valid}), 0);
                chk(int'(index) == exp_index, "index", int'(index), exp_index);
                chk(busy === 1'b1, "busy_running", int'(busy), 1);
                sres_left = GAP;
            end
            if (sres_left > 0) begin
                chk(dec_sreset === 1'b1, "sreset_high", int'(dec_sreset), 1);
                sres_left--;
                if (sres_left == 0) begin
                    if (front_end()) end_due = 1'b1;
                    else fetch_due = 1'b1;
                end
            end else begin
                chk(dec_sreset === 1'b0, "sreset_low", int'(dec_sreset), 0);
            end
            chk(song_end === cur_end, "song_end", int'(song_end), int'(cur_end));
            if (song_end === 1'b1) begin
                chk(busy === 1'b0, "busy_done", int'(busy), 0);
                if (front_end()) void'(exp_q.pop_front());
            end
            if (cur_fetch) chk(rd_req === 1'b1, "fetch_latency", int'(rd_req), 1);
            if (rd_req === 1'b1) begin
                chk(front_byte(), "rd_req_unexpected", 1, 0);
                chk(int'(rd_addr) == exp_addr, "rd_addr", int'(rd_addr), exp_addr);
            end
            if (rq_hold)
                chk(rd_req === 1'b1 && int'(rd_addr) == addr_prev, "rd_stable",
                    int'(rd_addr), addr_prev);
            if (dv_hold)
                chk(dec_valid === 1'b1 && int'(dec_data) == data_prev, "dec_stable",
                    int'(dec_data), data_prev);
        end

        restart_now = (RST === 1'b1) || (int'(current) != mon_cur);
        rq_hold     = (rd_req === 1'b1) && (rd_ack !== 1'b1) && !restart_now;
        dv_hold     = (dec_valid === 1'b1) && (dec_ready !== 1'b1) && !restart_now;
        addr_prev   = int'(rd_addr);
        data_prev   = int'(dec_data);

        if (restart_now) begin
            sel       = clampi(int'(current));
            mon_cur   = int'(current);
            exp_index = sel;
            exp_addr  = song_start[sel];
            exp_q.delete();
            for (int a = song_start[sel]; a < song_stop[sel]; a++)
                exp_q.push_back(int'(mem_byte(a)));
            exp_q.push_back(-1);
            end_due   = 1'b0;
            fetch_due = 1'b0;
            sres_left = 0;
            started   = 1'b1;
        end else if (started && dec_valid === 1'b1 && dec_ready === 1'b1) begin
            chk(front_byte(), "unexpected_byte", int'(dec_data), -1);
            if (front_byte()) begin
                chk(int'(dec_data) == exp_q[0], "dec_data", int'(dec_data), exp_q[0]);
                void'(exp_q.pop_front());
                exp_addr++;
                if (front_end()) end_due = 1'b1;
                else fetch_due = 1'b1;
            end
        end
        restart_prev = restart_now;
    end

    initial begin
        int n;
        RST     = 1'b1;
        current = 3'd0;
        repeat (3) @(posedge CLK);
        #2;
        RST = 1'b0;
        chk(dec_sreset === 1'b1 && busy === 1'b1, "reset_sreset", int'({dec_sreset, busy}), 3);
        chk(dec_data === 8'd0, "reset_dec_data", int'(dec_data), 0);
        chk(index === 3'd0, "reset_index", int'(index), 0);
        chk(rd_req === 1'b0 && dec_valid === 1'b0 && song_end === 1'b0, "reset_idle",
            int'({rd_req, dec_valid, song_end}), 0);
        wait_done(400);

        // Slow storage and a mostly-stalled decoder.
        ready_pct = 15;
        ack_force = 5;
        current   = 3'd3;
        wait_done(2000);
        ready_pct = 100;
        ack_force = -1;

        // Switch away while a byte is being accepted.
        current = 3'd0;
        n = 0;
        do begin
            @(posedge CLK);
            #2;
            n++;
        end while (dec_valid !== 1'b1 && n < 200);
        if (dec_valid !== 1'b1) chk(1'b0, "timeout_send", n, 200);
        current = 3'd2;
        wait_done(800);
        ready_pct = 60;

        // Switch away while a read is outstanding; its ack lands during the soft reset.
        ack_force = 4;
        current   = 3'd3;
        n = 0;
        do begin
            @(posedge CLK);
            #2;
            n++;
        end while (rd_req !== 1'b1 && n < 200);
        if (rd_req !== 1'b1) chk(1'b0, "timeout_fetch", n, 200);
        current = 3'd0;
        wait_done(800);
        ack_force = -1;

        current = 3'd6;
        wait_done(800);
        current = 3'd1;
        wait_done(800);

        for (int i = 0; i < 40; i++) begin
            current   = 3'($urandom_range(0, 7));
            ready_pct = int'($urandom_range(20, 100));
            if ($urandom_range(0, 1) == 1) begin
                wait_done(2000);
            end else begin
                repeat ($urandom_range(1, 25)) @(posedge CLK);
                #2;
            end
        end

        current = (current == 3'd2) ? 3'd0 : 3'd2;
        wait_done(800);
        repeat (4) @(posedge CLK);
        chk(exp_q.size() == 0, "queue_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
